// File: rtl/stage_mem_dport.sv
// Memory stage: issues data-cache requests with the dhit handshake, stalls on misses,
// and owns the MEM/WB pipeline register plus the sticky halt/misalign flags.
module stage_mem_dport #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned REGSEL_W   = 5,
  parameter int unsigned STALLCNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  valid_in,
  input  logic [WORD_W-1:0]     aluOut_in,
  input  logic [WORD_W-1:0]     storeData_in,
  input  logic                  memRead_in,
  input  logic                  memWrite_in,
  input  logic                  memtoReg_in,
  input  logic                  regWrite_in,
  input  logic [REGSEL_W-1:0]   regSel_in,
  input  logic                  jal_in,
  input  logic [WORD_W-1:0]     npc_in,
  input  logic                  halt_in,
  input  logic                  dhit,
  input  logic [WORD_W-1:0]     dmemload,
  output logic                  dmemREN,
  output logic                  dmemWEN,
  output logic [WORD_W-1:0]     dmemaddr,
  output logic [WORD_W-1:0]     dmemstore,
  output logic                  mem_stall,
  output logic                  misalign,
  output logic [STALLCNT_W-1:0] stall_cycles,
  output logic                  valid_out,
  output logic [WORD_W-1:0]     npc_out,
  output logic                  jal_out,
  output logic                  regWrite_out,
  output logic [REGSEL_W-1:0]   regSel_out,
  output logic                  memtoReg_out,
  output logic [WORD_W-1:0]     aluOut_out,
  output logic [WORD_W-1:0]     dmemload_out,
  output logic                  halt_out,
  output logic                  halted
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e state_q, state_d;
  logic   is_mem, aligned, memop, misaligned_op, req, accept;

  assign is_mem        = valid_in & (memRead_in | memWrite_in) & ~halted;
  assign aligned       = (aluOut_in[1:0] == 2'b00);
  assign memop         = is_mem & aligned;
  assign misaligned_op = is_mem & ~aligned;
  assign accept        = valid_in & ~halted;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      StIdle: begin
        req = memop;
        if (memop && !dhit) state_d = StWait;
      end
      StWait: begin
        // Upstream is frozen, so the request is rebuilt from the held inputs.
        req = memop;
        if (dhit || !memop) state_d = StIdle;
      end
    endcase
  end

  // Requests are gated by nRST so they drop the instant reset asserts.
  assign dmemREN   = nRST & req & memRead_in;
  assign dmemWEN   = nRST & req & memWrite_in & ~memRead_in;
  assign dmemaddr  = aluOut_in;
  assign dmemstore = storeData_in;
  assign mem_stall = nRST & memop & ~dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      misalign     <= 1'b0;
      stall_cycles <= '0;
      halted       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (misaligned_op) misalign <= 1'b1;
      if (mem_stall && (stall_cycles != {STALLCNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (!mem_stall && accept && halt_in) halted <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_out    <= 1'b0;
      npc_out      <= '0;
      jal_out      <= 1'b0;
      regWrite_out <= 1'b0;
      regSel_out   <= '0;
      memtoReg_out <= 1'b0;
      aluOut_out   <= '0;
      dmemload_out <= '0;
      halt_out     <= 1'b0;
    end else if (mem_stall || !accept) begin
      valid_out    <= 1'b0;
      npc_out      <= '0;
      jal_out      <= 1'b0;
      regWrite_out <= 1'b0;
      regSel_out   <= '0;
      memtoReg_out <= 1'b0;
      aluOut_out   <= '0;
      dmemload_out <= '0;
      halt_out     <= 1'b0;
    end else begin
      valid_out    <= 1'b1;
      npc_out      <= npc_in;
      jal_out      <= jal_in;
      regWrite_out <= regWrite_in & ~misaligned_op;
      regSel_out   <= regSel_in;
      memtoReg_out <= memtoReg_in;
      aluOut_out   <= aluOut_in;
      dmemload_out <= (memop && memRead_in && dhit) ? dmemload : '0;
      halt_out     <= halt_in;
    end
  end

endmodule

// File: tb/tb_stage_mem_dport.sv
// Directed bench for stage_mem_dport with a scoreboard of expected MEM/WB contents.
module tb_stage_mem_dport;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        valid_in, memRead_in, memWrite_in, memtoReg_in, regWrite_in, jal_in, halt_in;
  logic [31:0] aluOut_in, storeData_in, npc_in, dmemload;
  logic [4:0]  regSel_in;
  logic        dhit;
  logic        dmemREN, dmemWEN, mem_stall, misalign, valid_out, jal_out, regWrite_out;
  logic        memtoReg_out, halt_out, halted;
  logic [31:0] dmemaddr, dmemstore, npc_out, aluOut_out, dmemload_out;
  logic [15:0] stall_cycles;
  logic [4:0]  regSel_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  rs;
    logic [31:0] alu;
    logic [31:0] npc;
    logic        jal;
    logic [31:0] ld;
    logic        m2r;
    logic        h;
  } wb_t;

  wb_t sb[$];

  stage_mem_dport dut (
    .CLK(CLK), .nRST(nRST), .valid_in(valid_in), .aluOut_in(aluOut_in),
    .storeData_in(storeData_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .memtoReg_in(memtoReg_in), .regWrite_in(regWrite_in), .regSel_in(regSel_in),
    .jal_in(jal_in), .npc_in(npc_in), .halt_in(halt_in), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .misalign(misalign), .stall_cycles(stall_cycles),
    .valid_out(valid_out), .npc_out(npc_out), .jal_out(jal_out),
    .regWrite_out(regWrite_out), .regSel_out(regSel_out), .memtoReg_out(memtoReg_out),
    .aluOut_out(aluOut_out), .dmemload_out(dmemload_out), .halt_out(halt_out),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [31:0] alu,
                       input logic [31:0] sd, input logic rw, input logic [4:0] rs,
                       input logic m2r, input logic jal, input logic h, input logic hit,
                       input logic [31:0] ld);
    @(negedge CLK);
    valid_in = v; memRead_in = rd; memWrite_in = wr; aluOut_in = alu; storeData_in = sd;
    regWrite_in = rw; regSel_in = rs; memtoReg_in = m2r; jal_in = jal; halt_in = h;
    dhit = hit; dmemload = ld; npc_in = alu + 32'd4;
    #1;
  endtask

  function automatic wb_t mk(input logic v, input logic rw, input logic [4:0] rs,
                             input logic [31:0] alu, input logic jal, input logic [31:0] ld,
                             input logic m2r, input logic h);
    wb_t w;
    w.v = v; w.rw = rw; w.rs = rs; w.alu = alu; w.npc = v ? alu + 32'd4 : 32'd0;
    w.jal = jal; w.ld = ld; w.m2r = m2r; w.h = h;
    return w;
  endfunction

  function automatic wb_t bubble();
    return mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endfunction

  task automatic tick();
    wb_t e;
    @(posedge CLK);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("valid_out", valid_out, e.v);
      chk("regWrite_out", regWrite_out, e.rw);
      chk("regSel_out", regSel_out, e.rs);
      chk("aluOut_out", aluOut_out, e.alu);
      chk("npc_out", npc_out, e.npc);
      chk("jal_out", jal_out, e.jal);
      chk("dmemload_out", dmemload_out, e.ld);
      chk("memtoReg_out", memtoReg_out, e.m2r);
      chk("halt_out", halt_out, e.h);
    end
  endtask

  initial begin
    nRST = 1'b0;
    valid_in = 0; memRead_in = 0; memWrite_in = 0; memtoReg_in = 0; regWrite_in = 0;
    jal_in = 0; halt_in = 0; aluOut_in = 0; storeData_in = 0; npc_in = 0; dmemload = 0;
    regSel_in = 0; dhit = 0;
    repeat (2) @(negedge CLK);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_aluOut_out", aluOut_out, 32'd0);
    nRST = 1'b1;

    // ALU op
    drive(1, 0, 0, 32'h10, 0, 1, 5, 0, 1, 0, 0, 0);
    chk("alu_ren", dmemREN, 1'b0);
    chk("alu_wen", dmemWEN, 1'b0);
    chk("alu_stall", mem_stall, 1'b0);
    sb.push_back(mk(1, 1, 5, 32'h10, 1, 0, 0, 0));
    tick();

    // Load hit
    drive(1, 1, 0, 32'h100, 0, 1, 3, 1, 0, 0, 1, 32'hDEADBEEF);
    chk("hit_ren", dmemREN, 1'b1);
    chk("hit_addr", dmemaddr, 32'h100);
    chk("hit_stall", mem_stall, 1'b0);
    sb.push_back(mk(1, 1, 3, 32'h100, 0, 32'hDEADBEEF, 1, 0));
    tick();

    // Load miss: three stall cycles, then hit
    drive(1, 1, 0, 32'h104, 0, 1, 7, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge CLK);
        #1;
      end
      chk("miss_stall", mem_stall, 1'b1);
      chk("miss_ren", dmemREN, 1'b1);
      sb.push_back(bubble());
      tick();
    end
    drive(1, 1, 0, 32'h104, 0, 1, 7, 1, 0, 0, 1, 32'h12345678);
    chk("miss_done_stall", mem_stall, 1'b0);
    sb.push_back(mk(1, 1, 7, 32'h104, 0, 32'h12345678, 1, 0));
    tick();
    chk("miss_stall_cycles", stall_cycles, 32'd3);

    // dhit with nothing pending is ignored
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF);
    chk("idle_hit_ren", dmemREN, 1'b0);
    chk("idle_hit_stall", mem_stall, 1'b0);
    sb.push_back(bubble());
    tick();

    // Store miss, reset in the second wait cycle
    drive(1, 0, 1, 32'h200, 32'h5A, 0, 0, 0, 0, 0, 0, 0);
    chk("st_wen", dmemWEN, 1'b1);
    chk("st_ren", dmemREN, 1'b0);
    chk("st_data", dmemstore, 32'h5A);
    sb.push_back(bubble());
    tick();
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_mid_wen", dmemWEN, 1'b0);
    chk("rst_mid_stall", mem_stall, 1'b0);
    chk("rst_mid_stall_cycles", stall_cycles, 32'd0);
    chk("rst_mid_valid", valid_out, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b1;
    #1;
    chk("post_rst_wen", dmemWEN, 1'b0);

    // Read and write together: read wins
    drive(1, 1, 1, 32'h300, 32'h77, 1, 4, 1, 0, 0, 1, 32'hCAFE0001);
    chk("rw_ren", dmemREN, 1'b1);
    chk("rw_wen", dmemWEN, 1'b0);
    sb.push_back(mk(1, 1, 4, 32'h300, 0, 32'hCAFE0001, 1, 0));
    tick();

    // Misaligned load
    drive(1, 1, 0, 32'h102, 0, 1, 9, 1, 0, 0, 0, 0);
    chk("mis_ren", dmemREN, 1'b0);
    chk("mis_stall", mem_stall, 1'b0);
    sb.push_back(mk(1, 0, 9, 32'h102, 0, 0, 1, 0));
    tick();
    chk("mis_flag", misalign, 1'b1);

    // Halt that is also a store: store first, then halted
    drive(1, 0, 1, 32'h400, 32'h99, 0, 0, 0, 0, 1, 1, 0);
    chk("halt_wen", dmemWEN, 1'b1);
    sb.push_back(mk(1, 0, 0, 32'h400, 0, 0, 0, 1));
    tick();
    chk("halted_set", halted, 1'b1);

    // Load after halt: no request, bubble
    drive(1, 1, 0, 32'h100, 0, 1, 2, 1, 0, 0, 1, 32'h55);
    chk("post_halt_ren", dmemREN, 1'b0);
    sb.push_back(bubble());
    tick();
    chk("halted_hold", halted, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
